sram_prefetch_fifo: RTL and testbench

Parametrised SRAM-backed FIFO with valid/ready on both sides, concurrent push and pop, and a 2-entry prefetch buffer that hides SRAM read latency. Pop throughput is 1 word/cycle. It also provides fill level, almost-full/almost-empty thresholds and synchronous flush. It serves as the general stream buffer between encoder pipeline stages in the EC accelerator.

---
 rtl/sram_fifo_pkg.sv | 12 +
 rtl/sram_2p_wrapper.sv | 29 ++
 rtl/sram_prefetch_fifo.sv | 137 +++++++++++++
 tb/tb_sram_prefetch_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed prefetch FIFO.
//   PF_DEPTH : number of prefetch registers in front of the SRAM
//   ptr_w()  : ring pointer width (row address bits plus one wrap bit)
package sram_fifo_pkg;

  localparam int PF_DEPTH = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_2p_wrapper.sv
// Simple-dual-port (1R1W) SRAM model, WIDTH x DEPTH.
// Read data is registered, so it is valid one cycle after rd_en.
// Ports:
//   clk              clock
//   rd_en, rd_addr   read request; rd_data updates on the next edge
//   rd_data          registered read data
//   wr_en, wr_addr, wr_data  write port
module sram_2p_wrapper #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_prefetch_fifo.sv
// SRAM-backed stream FIFO with a 2-entry prefetch buffer in front of the
// SRAM. The prefetch buffer hides the one-cycle SRAM read latency, which
// gives single-cycle pop throughput. Total capacity is DEPTH+2 words.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous clear of all contents
//   in_valid/in_data   push side; in_ready depends on registered state only
//   out_valid/out_data pop side (head word); out_ready pops
//   level              words held (SRAM + read in flight + prefetch)
//   almost_full        level >= AFULL_TH
//   almost_empty       level <= AEMPTY_TH
//   empty              level == 0
module sram_prefetch_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int LVL_W     = $clog2(DEPTH + 3)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wptr, rptr;
  logic             rif;
  logic [WIDTH-1:0] pf [PF_DEPTH];
  logic             head;
  logic [1:0]       pf_cnt;

  logic             sram_empty, sram_full;
  logic             push, pop, bypass, sram_wr, rd_issue, pf_add, tail;
  logic [WIDTH-1:0] pf_din, rd_data;

  // Ring increment that wraps at DEPTH (works for non-power-of-2 DEPTH)
  // and toggles the wrap bit on the DEPTH-1 -> 0 transition.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
    return p + PW'(1);
  endfunction

  assign sram_empty = (wptr == rptr);
  assign sram_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign in_ready  = ~sram_full;
  assign out_valid = (pf_cnt != 2'd0);
  // pf entries and head are registers; the head word is a register select.
  assign out_data  = pf[head];

  assign empty        = (level == '0);
  assign almost_empty = (level <= LVL_W'(AEMPTY_TH));
  assign almost_full  = (level >= LVL_W'(AFULL_TH));

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;
    sram_wr  = 1'b0;
    rd_issue = 1'b0;
    pf_add   = 1'b0;
    pf_din   = rd_data;
    tail     = head ^ pf_cnt[0];
    if (!flush) begin
      push = in_valid & in_ready;
      pop  = out_valid & out_ready;
      // Bypass only when nothing older sits in SRAM or in flight, so a
      // bypassed word can never overtake earlier data.
      bypass = push & sram_empty & ~rif &
               (({1'b0, pf_cnt} - {2'b0, pop}) < 3'(PF_DEPTH));
      sram_wr = push & ~bypass;
      // Count the in-flight word as occupying a pf slot when deciding
      // whether another read fits.
      rd_issue = ~sram_empty &
                 (({1'b0, pf_cnt} + {2'b0, rif} - {2'b0, pop}) < 3'(PF_DEPTH));
      // Bypass requires rif==0 and landing requires rif==1: never both.
      pf_add = bypass | rif;
      pf_din = bypass ? in_data : rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      rif    <= 1'b0;
      head   <= 1'b0;
      pf_cnt <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < PF_DEPTH; i++) pf[i] <= '0;
    end else if (flush) begin
      // Clearing rif discards any read landing this cycle or next.
      wptr   <= '0;
      rptr   <= '0;
      rif    <= 1'b0;
      head   <= 1'b0;
      pf_cnt <= '0;
      level  <= '0;
    end else begin
      if (sram_wr)  wptr <= ptr_inc(wptr);
      if (rd_issue) rptr <= ptr_inc(rptr);
      rif <= rd_issue;
      if (pf_add) pf[tail] <= pf_din;
      if (pop)    head <= ~head;
      pf_cnt <= pf_cnt + 2'(pf_add) - 2'(pop);
      level  <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  sram_2p_wrapper #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rd_en   (rd_issue),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (sram_wr),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (in_data)
  );

endmodule

// File: tb/tb_sram_prefetch_fifo.sv
// Self-checking bench for sram_prefetch_fifo (DEPTH=8, capacity 10).
module tb_sram_prefetch_fifo;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 8;
  localparam int AFULL_TH  = 8;
  localparam int AEMPTY_TH = 2;
  localparam int LVL_W     = $clog2(DEPTH + 3);
  localparam int CAP       = DEPTH + 2;
  localparam int NV        = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, almost_full, almost_empty, empty;
  logic [WIDTH-1:0] out_data;
  logic [LVL_W-1:0] level;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q[$];
  int          m_level = 0;
  logic [31:0] nxt = 32'h0000_1000;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    int          lvl;
  } vec_t;
  vec_t vt [NV];

  sram_prefetch_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int lv);
    chk({tag, "_level"}, 32'(level), 32'(lv));
    chk({tag, "_empty"}, 32'(empty), 32'(lv == 0));
    chk({tag, "_aempty"}, 32'(almost_empty), 32'(lv <= AEMPTY_TH));
    chk({tag, "_afull"}, 32'(almost_full), 32'(lv >= AFULL_TH));
  endtask

  // One clock cycle against the queue model; entered and left at negedge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic acc_push, acc_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_level < CAP));
    acc_push = iv && (m_level < CAP) && !fl;
    acc_pop  = out_valid && ordy && !fl;
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      else if (acc_pop) chk("pop_data", out_data, q[0]);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_level = 0;
    end else begin
      if (acc_pop) void'(q.pop_front());
      if (acc_push) q.push_back(d);
      m_level = m_level + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
    end
    @(negedge clk);
    chk_flags("cyc", m_level);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && q.size() > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk({tag, "_drain_empty"}, 32'(empty), 32'd1);
    chk({tag, "_drain_ov"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // push/pop/flush rows; expected values hand-derived for DEPTH=8
    vt[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1};
    vt[1] = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 2};
    vt[2] = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 3};
    vt[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 2};
    vt[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 1};
    vt[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 0};
    vt[6] = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1};
    vt[7] = '{1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 1};
    vt[8] = '{1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 0};
    vt[9] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 0};

    // reset values, during and after reset
    repeat (3) @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", out_data, 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk_flags("rst", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_flags("rst_rel", 0);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      in_valid  = vt[i].iv;
      in_data   = vt[i].d;
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vt[i].ov));
      if (vt[i].ov) chk($sformatf("vec%0d_od", i), out_data, vt[i].od);
      chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'd1);
      chk_flags($sformatf("vec%0d", i), vt[i].lvl);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // fill to capacity, push while full is ignored, then drain in order
    for (int k = 1; k <= CAP; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
    chk("full_ir", 32'(in_ready), 32'd0);
    chk("full_af", 32'(almost_full), 32'd1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drain("fill");

    // full, then concurrent push/pop: in_ready back one cycle after first pop
    for (int k = 0; k < CAP; k++) cyc(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, nxt, 1'b1, 1'b0);
      nxt++;
      if (k == 0) chk("ir_recover", 32'(in_ready), 32'd1);
    end
    drain("conc");

    // primed with 4, streaming across three pointer wraps without bubbles
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      chk("no_bubble", 32'(out_valid), 32'd1);
      cyc(1'b1, nxt, 1'b1, 1'b0);
      nxt++;
      chk("stream_level", 32'(level), 32'd4);
    end
    drain("stream");

    // flush at level 6 with a read in flight
    for (int k = 0; k < 6; k++) cyc(1'b1, 32'h400 + 32'(k), 1'b0, 1'b0);
    cyc(1'b1, 32'h406, 1'b1, 1'b0);
    cyc(1'b1, 32'h0BAD, 1'b1, 1'b1);
    chk("flush_ov", 32'(out_valid), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("flush_no_stale", 32'(out_valid), 32'd0);
    end
    cyc(1'b1, 32'h1234, 1'b0, 1'b0);
    chk("post_flush_ov", 32'(out_valid), 32'd1);
    chk("post_flush_od", out_data, 32'h1234);
    drain("flush");

    // random valid/ready against the queue model
    for (int k = 0; k < 5000; k++) begin
      cyc(1'($urandom_range(0, 1)), nxt, 1'($urandom_range(0, 1)), 1'b0);
      nxt++;
    end
    drain("rand");

    // asynchronous reset in the middle of a cycle
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h500 + 32'(k), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od", out_data, 32'd0);
    chk("arst_ir", 32'(in_ready), 32'd1);
    chk_flags("arst", 0);
    q.delete();
    m_level = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 32'h600, 1'b0, 1'b0);
    chk("arst_push_od", out_data, 32'h600);
    drain("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
